// File: rtl/pipelined_write_decoder_pkg.sv
// Shared types and defaults for the register-write decoder slice.
package pipelined_write_decoder_pkg;

    localparam int unsigned DEFAULT_SEL_W    = 5;
    localparam int unsigned DEFAULT_ZERO_REG = 31;
    localparam int unsigned DEFAULT_OUTS     = 2 ** DEFAULT_SEL_W;

    typedef logic [DEFAULT_OUTS-1:0] onehot_t;

    function automatic onehot_t onehot(input logic [DEFAULT_SEL_W-1:0] sel);
        onehot_t v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Combinational SEL_W-to-2**SEL_W one-hot decoder with enable.
module onehot_decoder
    import pipelined_write_decoder_pkg::*;
#(
    parameter int unsigned SEL_W = DEFAULT_SEL_W
) (
    input  logic [SEL_W-1:0]      sel,
    input  logic                  en,
    output logic [2**SEL_W-1:0]   out
);

    always_comb begin
        out = '0;
        if (en) begin
            out[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/pipelined_write_decoder.sv
// One-hot regfile write decoder with an elastic output stage and a pending-write scoreboard.
module pipelined_write_decoder
    import pipelined_write_decoder_pkg::*;
#(
    parameter int unsigned SEL_W     = DEFAULT_SEL_W,
    parameter int unsigned ZERO_REG  = DEFAULT_ZERO_REG,
    parameter bit          MASK_ZERO = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_we,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2**SEL_W-1:0]   out_onehot,
    output logic [SEL_W-1:0]      out_sel,
    input  logic                  retire_valid,
    input  logic [SEL_W-1:0]      retire_sel,
    input  logic [SEL_W-1:0]      query_sel,
    output logic                  query_busy,
    output logic [2**SEL_W-1:0]   busy,
    output logic                  retire_err
);

    localparam int unsigned OUTS = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] ZSEL = SEL_W'(ZERO_REG);

    logic            accept;
    logic            set_en;
    logic            clr_en;
    logic [OUTS-1:0] set_vec;
    logic [OUTS-1:0] clr_vec;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign set_en   = accept && in_we && !(MASK_ZERO && in_sel == ZSEL);
    assign clr_en   = retire_valid && !(MASK_ZERO && retire_sel == ZSEL);

    onehot_decoder #(.SEL_W(SEL_W)) u_set_dec (
        .sel (in_sel),
        .en  (set_en),
        .out (set_vec)
    );

    onehot_decoder #(.SEL_W(SEL_W)) u_clr_dec (
        .sel (retire_sel),
        .en  (clr_en),
        .out (clr_vec)
    );

    assign query_busy = busy[query_sel];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_onehot <= '0;
            out_sel    <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_onehot <= set_vec;
            out_sel    <= in_sel;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
            out_onehot <= '0;
        end
    end

    // Set is applied after clear so a new write supersedes a same-cycle retire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy       <= '0;
            retire_err <= 1'b0;
        end else begin
            busy       <= (busy & ~clr_vec) | set_vec;
            retire_err <= |(clr_vec & ~busy & ~set_vec);
        end
    end

endmodule

// File: doc/pipelined_write_decoder.md
Name: pipelined_write_decoder

Overview:
Parametrised N-to-2^N one-hot register-write decoder with one elastic pipeline stage (valid/ready) and a pending-write scoreboard.
- Sits between decode and the register file.
- Produces the registered one-hot write-enable vector for the regfile.
- Tracks which destination registers have writes in flight, so hazard logic can query them.
- Optionally masks the hardwired zero register.

Parameters:
SEL_W, 5, select width; output width OUTS = 2**SEL_W
ZERO_REG, 31, index of hardwired zero register
MASK_ZERO, 1, 1 = writes to ZERO_REG decode to all-zero and never mark busy

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  request present
in_ready  output  1  stage can accept
in_sel  input  SEL_W  destination register index
in_we  input  1  request performs a write
out_valid  output  1  registered result present
out_ready  input  1  consumer accepts result
out_onehot  output  OUTS  registered one-hot write enable
out_sel  output  SEL_W  registered copy of accepted in_sel
retire_valid  input  1  a write has completed
retire_sel  input  SEL_W  index of completed write
query_sel  input  SEL_W  hazard query index
query_busy  output  1  combinational busy[query_sel]
busy  output  OUTS  scoreboard: 1 = write pending
retire_err  output  1  one-cycle pulse: retire of non-busy register

Behaviour:
- Reset:
  - Asserting reset at any time, including mid-transfer, clears out_valid, out_onehot, out_sel, busy and retire_err to 0 immediately.
  - In-flight data is discarded.
- Handshakes:
  - in_ready = !out_valid || out_ready (combinational; full throughput, no bubble).
  - Accept occurs when in_valid && in_ready.
- Data path, 1-cycle latency:
  - On accept, at the next edge: out_valid=1, out_sel=in_sel, out_onehot = decode(in_sel).
  - decode(in_sel) is bit in_sel set, all others 0.
  - out_onehot is forced to all-zero when in_we=0, or when MASK_ZERO=1 and in_sel==ZERO_REG.
  - out_valid still asserts for a zero vector.
- Hold:
  - While out_valid && !out_ready, out_valid, out_onehot and out_sel are held stable.
  - in_ready=0 during hold.
- Drain:
  - out_valid && out_ready with no new accept sets out_valid to 0 at the next edge.
  - out_onehot returns to 0 at that edge.
- Scoreboard, per edge:
  - busy |= set_vec, where set_vec = decode result on accept (else 0).
  - busy &= ~clr_vec, where clr_vec = one-hot of retire_sel when retire_valid (else 0).
  - The same bit set and cleared in the same cycle ends at busy=1 (set wins: the new write supersedes).
  - Retire of ZERO_REG when MASK_ZERO=1 is ignored, with no error.
- retire_err:
  - Registered; equals 1 for exactly the cycle after retire_valid targets a bit whose busy is 0 and is not being set that cycle.
  - Otherwise 0.
- query_busy:
  - Reflects the current registered busy only.
  - No bypass of same-cycle set or clear.
- Widths:
  - in_sel is always in range (0..OUTS-1), so there is no out-of-range case.
- No internal state machine beyond the out_valid flag and the scoreboard.

Decomposition:
- Package pipelined_write_decoder_pkg:
  - onehot_t width helper.
  - Function onehot(sel) returning a 2**SEL_W vector.
  - Constant DEFAULT_ZERO_REG=31.
- One sub-module, onehot_decoder:
  - Purely combinational, parametrised SEL_W.
  - Ports sel, en, out.
  - Instantiated twice: set path and retire path.

Test Plan (SEL_W=5):
- Reset, then in_valid=1, in_sel=3, in_we=1, out_ready=1 -> next cycle out_valid=1, out_onehot=32'h0000_0008, busy[3]=1; query_sel=3 -> query_busy=1.
- in_sel=31, in_we=1 (MASK_ZERO=1) -> out_onehot=0, out_valid=1, busy unchanged; repeat with in_we=0, in_sel=7 -> out_onehot=0, busy[7]=0.
- out_ready=0 with in_sel=5 accepted, then in_sel=9 offered for 3 cycles -> out_onehot stays 32'h20, in_ready=0; out_ready=1 -> next cycle out_onehot=32'h200; back-to-back accepts give one result per cycle.
- busy[4]=1, same cycle accept in_sel=4 and retire_sel=4 -> busy[4]=1, retire_err=0; next cycle retire_sel=4 alone -> busy[4]=0.
- retire_valid=1, retire_sel=12 with busy[12]=0 -> retire_err=1 for exactly one cycle, busy unchanged.
- Assert reset asynchronously mid-cycle while out_valid=1 and busy=32'h0000_0108 -> all outputs 0 immediately, before the next clk edge.
